// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide sequencer.
package muldiv_pkg;

  localparam int ITER = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: right-shift shift-add for multiply,
// left-shift restoring subtract for divide, on a {upper, lower} register pair.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] pr,
  input  logic [WIDTH-1:0]   opnd,
  input  logic               isDiv,
  output logic [2*WIDTH-1:0] prNext
);

  logic [WIDTH:0] addSum;
  logic [WIDTH:0] shRem;
  logic [WIDTH:0] diff;

  always_comb begin
    addSum = {1'b0, pr[2*WIDTH-1:WIDTH]} + (pr[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    shRem  = pr[2*WIDTH-1:WIDTH-1];
    // remainder stays below the divisor, so bit WIDTH of diff is a clean borrow
    diff   = shRem - {1'b0, opnd};
    if (isDiv) begin
      if (!diff[WIDTH]) prNext = {diff[WIDTH-1:0], pr[WIDTH-2:0], 1'b1};
      else              prNext = {shRem[WIDTH-1:0], pr[WIDTH-2:0], 1'b0};
    end else begin
      prNext = {addSum, pr[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// MULDIV_HILO_WRITE_EN adds hi_wr/lo_wr/wdata for MTHI/MTLO while idle.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef MULDIV_HILO_WRITE_EN
  input  logic             hi_wr,
  input  logic             lo_wr,
  input  logic [WIDTH-1:0] wdata,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state, nextState;
  logic [CNT_W-1:0]   cnt;
  op_t                opR;
  logic [2*WIDTH-1:0] pr, prNext;
  logic [WIDTH-1:0]   opnd;
  logic               negLo, negHi, dzR;
  logic               isSigned, isDivR;

  assign isSigned = (opR == OP_MULT) || (opR == OP_DIV);
  assign isDivR   = (opR == OP_DIV)  || (opR == OP_DIVU);

  muldiv_step #(.WIDTH(WIDTH)) uStep (
    .pr     (pr),
    .opnd   (opnd),
    .isDiv  (isDivR),
    .prNext (prNext)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= nextState;
  end

  always_comb begin
    nextState = state;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    div_zero  = 1'b0;
    case (state)
      S_IDLE: if (start) nextState = S_PREP;
      // divide-by-zero spends its one busy cycle here and skips the iterations
      S_PREP: nextState = dzR ? S_DONE : S_RUN;
      S_RUN:  if (cnt == CNT_W'(WIDTH-1)) nextState = S_FIX;
      S_FIX:  nextState = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        div_zero  = dzR;
        nextState = S_IDLE;
      end
      default: nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      pr    <= '0;
      opnd  <= '0;
      opR   <= OP_MULT;
      negLo <= 1'b0;
      negHi <= 1'b0;
      dzR   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            pr   <= {{WIDTH{1'b0}}, a};
            opnd <= b;
            opR  <= op_t'(op);
            dzR  <= op[1] && (b == '0);
          end
`ifdef MULDIV_HILO_WRITE_EN
          if (hi_wr) hi <= wdata;
          if (lo_wr) lo <= wdata;
`endif
        end
        S_PREP: begin
          cnt <= '0;
          if (isSigned && pr[WIDTH-1])   pr[WIDTH-1:0] <= -pr[WIDTH-1:0];
          if (isSigned && opnd[WIDTH-1]) opnd <= -opnd;
          // negLo: product or quotient sign; negHi: remainder follows dividend
          negLo <= isSigned && (pr[WIDTH-1] ^ opnd[WIDTH-1]);
          negHi <= isSigned && pr[WIDTH-1];
        end
        S_RUN: begin
          pr  <= prNext;
          cnt <= cnt + 1'b1;
        end
        S_FIX: begin
          if (isDivR) begin
            lo <= negLo ? -pr[WIDTH-1:0]       : pr[WIDTH-1:0];
            hi <= negHi ? -pr[2*WIDTH-1:WIDTH] : pr[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= negLo ? -pr : pr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Randomized self-checking bench for muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;
`ifdef MULDIV_HILO_WRITE_EN
  logic        hi_wr = 1'b0, lo_wr = 1'b0;
  logic [31:0] wdata = '0;
`endif

  int          checks = 0;
  int          failures = 0;
  logic [31:0] mHi = '0, mLo = '0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
`ifdef MULDIV_HILO_WRITE_EN
    .hi_wr    (hi_wr),
    .lo_wr    (lo_wr),
    .wdata    (wdata),
`endif
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // returns {hi, lo} after the operation
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] x, y, h, l);
    longint      sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = {h, l};
    case (o)
      2'd0: p = 64'(sx * sy);
      2'd1: p = {32'd0, x} * {32'd0, y};
      2'd2: if (y != 0) begin
              q = sx / sy;
              r = sx % sy;
              p = {r[31:0], q[31:0]};
            end
      default: if (y != 0) p = {x % y, x / y};
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // glitchAt / rstAt: cycle index after the start edge (-1 = unused)
  task automatic runOp(input logic [1:0] o, input logic [31:0] x, y,
                       input int glitchAt, input int rstAt);
    int          cyc;
    bit          busyBad;
    int          expLat;
    logic        expDz;
    logic [63:0] res;
    expDz  = o[1] && (y == 0);
    expLat = expDz ? 1 : 34;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    #1;
    start = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
    cyc = 0; busyBad = 0;
    @(negedge clk);
    while (cyc < 60) begin
      if (rstAt >= 0 && cyc == rstAt + 1) break;
      if (done) break;
      if (!busy) busyBad = 1;
      start = (cyc == glitchAt);
      if (start) begin a = $urandom; b = $urandom; op = 2'($urandom); end
      if (cyc == rstAt) reset = 1'b0;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (rstAt >= 0) begin
      chk("rst_lat", cyc, rstAt + 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      reset = 1'b1;
      mHi = '0; mLo = '0;
    end else begin
      res = refModel(o, x, y, mHi, mLo);
      {mHi, mLo} = res;
      chk("latency", cyc, expLat);
      chk("busy_run", busyBad, 0);
      chk("busy_done", busy, 1);
      chk("div_zero", div_zero, expDz);
      chk("hi", hi, mHi);
      chk("lo", lo, mLo);
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dz", div_zero, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    reset = 1'b1;

    runOp(2'd0, 32'hFFFF_FFFF, 32'h2, -1, -1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);
    runOp(2'd1, 32'hFFFF_FFFF, 32'h2, -1, -1);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);
    runOp(2'd2, 32'hFFFF_FFF9, 32'h2, -1, -1);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    runOp(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    chk("divwrap_lo", lo, 32'h8000_0000);
    chk("divwrap_hi", hi, 32'h0);

    // 0x22 * 0x80000001 = 0x11_00000022
    runOp(2'd1, 32'h22, 32'h8000_0001, -1, -1);
    runOp(2'd3, 32'd7, 32'd0, -1, -1);
    chk("dz_hi", hi, 32'h11);
    chk("dz_lo", lo, 32'h22);

    runOp(2'd3, 32'd100, 32'd7, 11, -1);
    chk("ign_lo", lo, 32'd14);
    chk("ign_hi", hi, 32'd2);

    runOp(2'd0, 32'd3, 32'd5, -1, 11);
    runOp(2'd0, 32'd3, 32'd5, -1, -1);
    chk("post_rst_lo", lo, 32'd15);
    chk("post_rst_hi", hi, 32'd0);

    for (int i = 0; i < 40; i++)
      runOp(2'($urandom_range(0, 3)), pick(), pick(), -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
